// File: rtl/boe_pkg.sv
// Shared types and widths for the BOE feeder: FSM state encoding and group-size limits.
package boe_pkg;
    localparam int MAX_N  = 7;
    localparam int DATA_W = 8;
    localparam int NUM_W  = 3;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SEND    = 2'd1,
        WAIT    = 2'd2
    } state_e;
endpackage

// File: rtl/boe_group_buf.sv
// Seven-byte group buffer with write and read pointers; the read port forwards a byte
// being written in the same cycle so a group can start sending on its closing beat.
module boe_group_buf
    import boe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [NUM_W-1:0]  wr_ptr_o,
    output logic [NUM_W-1:0]  rd_ptr_o,
    output logic [DATA_W-1:0] rd_data_o
);
    logic [DATA_W-1:0] mem_q [MAX_N];
    logic [NUM_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [NUM_W-1:0]  rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en_i) wr_ptr_d = wr_ptr_q + NUM_W'(1);
            if (rd_en_i) rd_ptr_d = rd_ptr_q + NUM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_comb begin
        rd_data_o = '0;
        if (wr_en_i && (wr_ptr_q == rd_ptr_q))
            rd_data_o = wr_data_i;
        else if (rd_ptr_q < NUM_W'(MAX_N))
            rd_data_o = mem_q[rd_ptr_q];
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
endmodule

// File: rtl/boe_feeder.sv
// Groups up to seven upstream bytes and replays them to the BOE with a trailing idle gap.
// Define BOE_FEEDER_TIMEOUT_EN to flush a partial group after TIMEOUT idle cycles.
module boe_feeder
    import boe_pkg::*;
#(
    parameter int GAP_EXTRA = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [NUM_W-1:0]  data_num,
    output logic [DATA_W-1:0] data_in,
    output logic              busy
);
    state_e            state_q, state_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [3:0]        wcnt_q, wcnt_d;

    logic              accept, close, timeout;
    logic              wr_en, rd_en, clr;
    logic [NUM_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W-1:0] rd_data;

    boe_group_buf u_buf (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (clr),
        .wr_en_i   (wr_en),
        .wr_data_i (in_data),
        .rd_en_i   (rd_en),
        .wr_ptr_o  (wr_ptr),
        .rd_ptr_o  (rd_ptr),
        .rd_data_o (rd_data)
    );

    assign in_ready = (state_q == COLLECT) && !reset;
    assign accept   = in_valid && in_ready;
    assign close    = accept && (in_last || (wr_ptr == NUM_W'(MAX_N - 1)));
    assign busy     = !reset && ((state_q != COLLECT) || (wr_ptr != '0));
    assign data_num = num_q;
    assign data_in  = dat_q;

`ifdef BOE_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;

    assign timeout = (state_q == COLLECT) && (wr_ptr != '0) && !accept &&
                     (tcnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        tcnt_d = tcnt_q + TW'(1);
        if ((state_q != COLLECT) || accept || (wr_ptr == '0) || timeout)
            tcnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) tcnt_q <= '0;
        else       tcnt_q <= tcnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout        = 1'b0;
`endif

    // Outputs are computed one cycle ahead so data_num/data_in come straight from flops.
    always_comb begin
        state_d = state_q;
        num_d   = '0;
        dat_d   = '0;
        wcnt_d  = wcnt_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr     = 1'b0;
        case (state_q)
            COLLECT: begin
                wr_en = accept;
                if (close || timeout) begin
                    state_d = SEND;
                    num_d   = accept ? wr_ptr + NUM_W'(1) : wr_ptr;
                    dat_d   = rd_data;
                    rd_en   = 1'b1;
                end
            end
            SEND: begin
                if (rd_ptr != wr_ptr) begin
                    dat_d = rd_data;
                    rd_en = 1'b1;
                end else begin
                    state_d = WAIT;
                    wcnt_d  = {1'b0, wr_ptr} + 4'(GAP_EXTRA) - 4'd1;
                end
            end
            WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = COLLECT;
                    clr     = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            num_q   <= '0;
            dat_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            dat_q   <= dat_d;
            wcnt_q  <= wcnt_d;
        end
    end
endmodule
